// File: rtl/bootrom_bist_if.sv
// Port bundle between the BIST engine and the dual-port boot/OSD RAM.
// Port 1 is the byte-selectable write port, port 2 the registered read port.
interface bootrom_bist_if #(
   parameter int unsigned ADDR_WIDTH = 13
);
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           d;
   logic                  we;
   logic [3:0]            bytesel;
   logic [ADDR_WIDTH-1:0] addr2;
   logic [31:0]           q2;

   // BIST engine side: drives both ports, receives read data
   modport master (
      output addr, d, we, bytesel, addr2,
      input  q2
   );

   // RAM side
   modport slave (
      input  addr, d, we, bytesel, addr2,
      output q2
   );
endinterface

// File: rtl/bootrom_bist.sv
// Boot/OSD RAM self-test: full-word fill with an address-derived pattern,
// single-lane inverting write pass, then read-back and compare through port 2.
// All outputs are registered; outputs are decoded from the next state so the
// first write appears the cycle after start is accepted.
module bootrom_bist #(
   parameter int unsigned ADDR_WIDTH = 13,
   parameter int unsigned RD_LAT     = 1,
   parameter logic [31:0] SEED       = 32'hAABBCCDD
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [15:0]           err_count,
   output logic [ADDR_WIDTH-1:0] err_addr,
   bootrom_bist_if.master        ram
);

   typedef logic [ADDR_WIDTH-1:0] addr_t;
   localparam addr_t ADDR_MAX  = '1;
   localparam addr_t DRAIN_END = addr_t'(RD_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_BYTEWR,
      S_VERIFY,
      S_DRAIN,
      S_DONE
   } state_t;

   // P(a): base pattern
   function automatic logic [31:0] pat(input addr_t a);
      return SEED ^ 32'(a);
   endfunction

   // E(a): pattern with lane a[1:0] inverted
   function automatic logic [31:0] expv(input addr_t a);
      return pat(a) ^ (32'h0000_00FF << {a[1:0], 3'b000});
   endfunction

   state_t        state_q, state_d;
   addr_t         cnt_q, cnt_d;
   logic          start_acc;

   addr_t         addr_q, addr_d;
   logic [31:0]   d_q, d_d;
   logic          we_q, we_d;
   logic [3:0]    bs_q, bs_d;
   addr_t         addr2_q, addr2_d;
   logic          rdv_q, rdv_d;

   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          pass_q, pass_d;
   logic [15:0]   errc_q, errc_d;
   addr_t         erra_q, erra_d;

   logic          dl_vld_q  [RD_LAT];
   addr_t         dl_addr_q [RD_LAT];
   logic          mism;

   // Next-state and address/drain counter sequencing
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      start_acc = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d   = S_FILL;
               cnt_d     = '0;
               start_acc = 1'b1;
            end
         end
         S_FILL: begin
            if (cnt_q == ADDR_MAX) begin
               state_d = S_BYTEWR;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BYTEWR: begin
            if (cnt_q == ADDR_MAX) begin
               state_d = S_VERIFY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_VERIFY: begin
            if (cnt_q == ADDR_MAX) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_q == DRAIN_END) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // RAM port values decoded from the upcoming state, then registered
   always_comb begin
      addr_d  = '0;
      d_d     = '0;
      we_d    = 1'b0;
      bs_d    = '0;
      addr2_d = '0;
      rdv_d   = 1'b0;
      case (state_d)
         S_FILL: begin
            addr_d = cnt_d;
            d_d    = pat(cnt_d);
            we_d   = 1'b1;
            bs_d   = 4'b1111;
         end
         S_BYTEWR: begin
            addr_d = cnt_d;
            d_d    = ~pat(cnt_d);
            we_d   = 1'b1;
            bs_d   = 4'b0001 << cnt_d[1:0];
         end
         S_VERIFY: begin
            addr2_d = cnt_d;
            rdv_d   = 1'b1;
         end
         S_DRAIN: begin
            addr2_d = addr2_q;
         end
         default: ;
      endcase
   end

   // Compare returning data and update error status
   always_comb begin
      mism   = dl_vld_q[RD_LAT-1] && (ram.q2 != expv(dl_addr_q[RD_LAT-1]));
      errc_d = errc_q;
      erra_d = erra_q;
      if (start_acc) begin
         errc_d = '0;
         erra_d = '0;
      end else if (mism) begin
         if (errc_q != 16'hFFFF) begin
            errc_d = errc_q + 16'd1;
         end
         if (errc_q == 16'd0) begin
            erra_d = dl_addr_q[RD_LAT-1];
         end
      end
      busy_d = (state_d == S_FILL) || (state_d == S_BYTEWR) ||
               (state_d == S_VERIFY) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
      pass_d = (state_d == S_DONE) && (errc_d == 16'd0);
   end

   // State, port and status registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         d_q     <= '0;
         we_q    <= 1'b0;
         bs_q    <= '0;
         addr2_q <= '0;
         rdv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         errc_q  <= '0;
         erra_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         d_q     <= d_d;
         we_q    <= we_d;
         bs_q    <= bs_d;
         addr2_q <= addr2_d;
         rdv_q   <= rdv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         errc_q  <= errc_d;
         erra_q  <= erra_d;
      end
   end

   // Read-address delay line: fed from the registered addr2, so its tail
   // lines up with q2 from a registered-output RAM of latency RD_LAT
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < RD_LAT; i++) begin
            dl_vld_q[i]  <= 1'b0;
            dl_addr_q[i] <= '0;
         end
      end else begin
         dl_vld_q[0]  <= rdv_q;
         dl_addr_q[0] <= addr2_q;
         for (int unsigned i = 1; i < RD_LAT; i++) begin
            dl_vld_q[i]  <= dl_vld_q[i-1];
            dl_addr_q[i] <= dl_addr_q[i-1];
         end
      end
   end

   assign ram.addr    = addr_q;
   assign ram.d       = d_q;
   assign ram.we      = we_q;
   assign ram.bytesel = bs_q;
   assign ram.addr2   = addr2_q;

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign err_count = errc_q;
   assign err_addr  = erra_q;

endmodule

// File: tb/tb_bootrom_bist.sv
// Bench for bootrom_bist with a 16-word RAM model (good, stuck bit, lane
// decode ignored) on an RD_LAT=1 instance, and a 1- or 2-cycle RAM on an
// RD_LAT=2 instance.
module tb_bootrom_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n  = 1'b0;
   logic start1 = 1'b0;
   logic start2 = 1'b0;

   logic       busy1, done1, pass1;
   logic [15:0] errc1;
   logic [3:0] erra1;
   logic       busy2, done2, pass2;
   logic [15:0] errc2;
   logic [3:0] erra2;

   bootrom_bist_if #(.ADDR_WIDTH(4)) if1 ();
   bootrom_bist_if #(.ADDR_WIDTH(4)) if2 ();

   bootrom_bist #(.ADDR_WIDTH(4), .RD_LAT(1), .SEED(32'hAABBCCDD)) dut1 (
      .clk(clk), .reset_n(rst_n), .start(start1),
      .busy(busy1), .done(done1), .pass(pass1),
      .err_count(errc1), .err_addr(erra1), .ram(if1.master)
   );

   bootrom_bist #(.ADDR_WIDTH(4), .RD_LAT(2), .SEED(32'hAABBCCDD)) dut2 (
      .clk(clk), .reset_n(rst_n), .start(start2),
      .busy(busy2), .done(done2), .pass(pass2),
      .err_count(errc2), .err_addr(erra2), .ram(if2.master)
   );

   // RAM model 1: mode 0 good, 1 bit0 of word 5 stuck at 1, 2 ignores bytesel
   int          mode1 = 0;
   logic [31:0] mem1 [16];
   int          wr1   = 0;
   int          coll1 = 0;
   always @(posedge clk) begin
      if (if1.we) begin
         for (int n = 0; n < 4; n++)
            if (if1.bytesel[n] || mode1 == 2) mem1[if1.addr][8*n +: 8] <= if1.d[8*n +: 8];
         wr1 <= wr1 + 1;
         if (if1.addr2 != 4'd0) coll1 <= coll1 + 1;
      end
      if1.q2 <= mem1[if1.addr2] | ((mode1 == 1 && if1.addr2 == 4'd5) ? 32'd1 : 32'd0);
   end

   // RAM model 2: good RAM with selectable 1- or 2-cycle read latency
   logic        lat2 = 1'b1;
   logic [31:0] mem2 [16];
   logic [31:0] q2a, q2b;
   always @(posedge clk) begin
      if (if2.we)
         for (int n = 0; n < 4; n++)
            if (if2.bytesel[n]) mem2[if2.addr][8*n +: 8] <= if2.d[8*n +: 8];
      q2a <= mem2[if2.addr2];
      q2b <= q2a;
   end
   assign if2.q2 = lat2 ? q2b : q2a;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic       we;
      logic [3:0] bs;
      logic [3:0] addr;
      logic [31:0] d;
      logic [3:0] addr2;
      logic       busy;
   } snap_t;
   snap_t snap [256];

   // Accept a start on dut1 and count edges until done; optional second
   // start pulse at cycle restart_at
   task automatic run1(input int restart_at, output int len);
      @(negedge clk) start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      chk("start_busy", {31'd0, busy1}, 32'd1);
      chk("start_done_clr", {30'd0, done1, pass1}, 32'd0);
      chk("start_err_clr", {12'd0, erra1, errc1}, 32'd0);
      snap[0] = '{if1.we, if1.bytesel, if1.addr, if1.d, if1.addr2, busy1};
      len = 0;
      while (!done1 && len < 200) begin
         @(posedge clk); #1;
         len++;
         snap[len] = '{if1.we, if1.bytesel, if1.addr, if1.d, if1.addr2, busy1};
         start1 = (len == restart_at);
      end
      start1 = 1'b0;
   endtask

   task automatic run2(output int len);
      @(negedge clk) start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      len = 0;
      while (!done2 && len < 200) begin
         @(posedge clk); #1;
         len++;
      end
   endtask

   typedef struct {
      int          mode;
      logic        exp_pass;
      logic [15:0] exp_cnt;
      logic [3:0]  exp_addr;
   } vec_t;
   vec_t tbl [4];

   initial begin
      int len, wr0;

      tbl[0] = '{0, 1'b1, 16'd0,  4'd0};
      tbl[1] = '{1, 1'b0, 16'd1,  4'd5};
      tbl[2] = '{2, 1'b0, 16'd16, 4'd0};
      tbl[3] = '{0, 1'b1, 16'd0,  4'd0};

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_status1", {busy1, done1, pass1, errc1, erra1}, 32'd0);
      chk("rst_port1", {if1.we, if1.bytesel, if1.addr, if1.addr2}, 32'd0);
      chk("rst_d1", if1.d, 32'd0);
      chk("rst_status2", {busy2, done2, pass2, errc2, erra2}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 4; i++) begin
         mode1 = tbl[i].mode;
         wr0 = wr1;
         run1(-1, len);
         chk($sformatf("v%0d_len", i), len, 49);
         chk($sformatf("v%0d_pass", i), {31'd0, pass1}, {31'd0, tbl[i].exp_pass});
         chk($sformatf("v%0d_cnt", i), {16'd0, errc1}, {16'd0, tbl[i].exp_cnt});
         chk($sformatf("v%0d_addr", i), {28'd0, erra1}, {28'd0, tbl[i].exp_addr});
         chk($sformatf("v%0d_busy", i), {31'd0, busy1}, 32'd0);
         chk($sformatf("v%0d_writes", i), wr1 - wr0, 32);
      end
      chk("collisions", coll1, 0);

      // Contents after a good run and the port sequence of that run
      chk("mem_word2", mem1[2], 32'hAA44CCDF);
      chk("mem_word5", mem1[5], 32'hAABB33D8);
      chk("fill0", {snap[0].we, snap[0].bs, snap[0].addr, snap[0].addr2}, {1'b1, 4'hF, 4'd0, 4'd0});
      chk("fill0_d", snap[0].d, 32'hAABBCCDD);
      chk("fill15", {snap[15].we, snap[15].bs, snap[15].addr}, {1'b1, 4'hF, 4'd15});
      chk("fill15_d", snap[15].d, 32'hAABBCCD2);
      chk("bw0", {snap[16].we, snap[16].bs, snap[16].addr}, {1'b1, 4'b0001, 4'd0});
      chk("bw0_d", snap[16].d, 32'h55443322);
      chk("bw3", {snap[19].bs, snap[19].addr}, {4'b1000, 4'd3});
      chk("bw3_d", snap[19].d, 32'h55443321);
      chk("bw15", {snap[31].we, snap[31].bs, snap[31].addr}, {1'b1, 4'b1000, 4'd15});
      chk("ver0", {snap[32].we, snap[32].bs, snap[32].addr2}, {1'b0, 4'd0, 4'd0});
      chk("ver15", {snap[47].we, snap[47].addr2}, {1'b0, 4'd15});
      chk("drain_hold", {snap[48].busy, snap[48].addr2}, {1'b1, 4'd15});
      chk("done_idle", {snap[49].busy, snap[49].addr2}, {1'b0, 4'd0});

      // Reset mid-FILL
      mode1 = 0;
      @(negedge clk) start1 = 1'b1;
      @(posedge clk); #1 start1 = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_we", {31'd0, if1.we}, 32'd0);
      chk("midrst_status", {busy1, done1, pass1, errc1, erra1}, 32'd0);
      chk("midrst_port", {if1.bytesel, if1.addr, if1.addr2}, 32'd0);
      @(negedge clk) rst_n = 1'b1;
      run1(-1, len);
      chk("postrst_len", len, 49);
      chk("postrst_pass", {31'd0, pass1}, 32'd1);

      // Start while busy is ignored
      run1(10, len);
      chk("restart_len", len, 49);
      chk("restart_pass", {31'd0, pass1}, 32'd1);
      repeat (3) @(posedge clk);
      #1 chk("done_hold", {busy1, done1, pass1}, 32'b011);

      // RD_LAT=2 with matching and mismatched RAM latency
      lat2 = 1'b1;
      run2(len);
      chk("lat2_len", len, 50);
      chk("lat2_pass", {31'd0, pass2}, 32'd1);
      chk("lat2_cnt", {16'd0, errc2}, 32'd0);
      lat2 = 1'b0;
      run2(len);
      chk("lat2_fast_len", len, 50);
      chk("lat2_fast_pass", {31'd0, pass2}, 32'd0);
      chk("lat2_fast_cnt", {16'd0, errc2}, 32'd15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
